mem1_copy_engine: RTL and testbench
===================================

Name: mem1_copy_engine

Overview:
- Initiator for the single-port 32x5 memory (`mem1`) port: `w_en`, `mode`, `address`, `data_in`, `data_out`.
- Accepts a copy command (src, dst, len) and moves len words from src to dst through that one port, alternating read and write accesses.
- Sits between control logic and `mem1`, and also serves as the block-move / self-test driver for it.

Parameters:
- AW, 5, address width; memory depth 2**AW.
- DW, 5, data word width.
- RD_LAT, 1, cycles from the read-issue clock edge until `mem_data_out` is valid and captured; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src  in  AW  source start address; latched on accepted start.
- dst  in  AW  destination start address; latched on accepted start.
- len  in  AW+1  word count 0..32; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- mem_w_en  out  1  to mem `w_en`; high on write cycles only.
- mem_mode  out  1  to mem `mode`; 1 = read cycle, 0 = write/idle.
- mem_address  out  AW  to mem `address`.
- mem_data_in  out  DW  to mem `data_in`.
- mem_data_out  in  DW  from mem `data_out`.

Behaviour:
- Reset: synchronous, active-high; one clock, clk.
  - On reset: state = IDLE; busy = 0, done = 0, mem_w_en = 0, mem_mode = 0, mem_address = 0, mem_data_in = 0.
  - Internal counters, pointers and the data latch are cleared.
- Reset mid-operation:
  - Aborts at that edge.
  - No further memory access is issued.
  - No done pulse is produced.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - Outputs are idle (w_en = 0, mode = 0).
  - start = 1 latches src/dst/len.
  - If len = 0: go to DONE.
  - Otherwise: go to RD.
- RD (1 cycle): mem_mode = 1, mem_w_en = 0, mem_address = src pointer. Next state is WAIT.
- WAIT (RD_LAT cycles):
  - Outputs are idle.
  - On the last WAIT cycle, mem_data_out is latched into the data register.
  - Then go to WR.
- WR (1 cycle):
  - mem_w_en = 1, mem_mode = 0, mem_address = dst pointer, mem_data_in = latched word.
  - At the end of the cycle, src and dst pointers each increment modulo 2**AW (31 wraps to 0), and the remaining count decrements.
  - If the count becomes 0: go to DONE; otherwise go to RD.
- DONE (1 cycle): done = 1, busy = 0. Next state is IDLE.
- Outputs are registered from state (Moore). busy = 1 in RD, WAIT and WR.
- Latency:
  - Per word: 2 + RD_LAT cycles.
  - Command: len × (2 + RD_LAT) cycles, plus 1 cycle for DONE.
  - len = 0: done pulses on the cycle after start, with zero memory accesses.
- Handshakes:
  - start while busy or in DONE is ignored; no queuing.
  - A start in the same cycle as rst is dropped.
- Overlap:
  - The copy is always forward, word by word.
  - If dst lies inside (src, src+len), already-written words are re-read.
  - The result is defined by this sequential order, with no special handling.
- len = 32 copies the entire memory with wrap. len > 32 is not representable.

Optional Feature:
- Macro: CHECKSUM_EN.
- With CHECKSUM_EN defined:
  - Extra output port `checksum`, width DW.
  - Cleared on an accepted start and by rst.
  - XOR-accumulates each latched word at its WR cycle.
  - Holds its value after done until the next accepted start.
- Without CHECKSUM_EN: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst = 1 for 1 cycle with start = 1 → all outputs 0, state IDLE, no memory activity, no done.
- Basic copy, RD_LAT = 1, memory preloaded with [5] = 27, [6] = 26, [7] = 25; start with src = 5, dst = 20, len = 3:
  - Expect 9 busy cycles, done on cycle 10.
  - Memory [20..22] = 27, 26, 25.
  - Access order on the port is R5, W20, R6, W21, R7, W22.
  - With CHECKSUM_EN: checksum = 27^26^25 = 24.
- Wrap-around: src = 30, dst = 2, len = 4, memory [30] = 1, [31] = 2, [0] = 3, [1] = 4 → memory [2..5] = 1, 2, 3, 4; read addresses 30, 31, 0, 1.
- len = 0 and ignored start:
  - start with len = 0 → done exactly 1 cycle later, mem_w_en never high.
  - A second start pulsed mid-copy → no effect; done pulses once.
- Reset mid-operation: start with src = 0, dst = 16, len = 8; assert rst after the 2nd WR → only [16], [17] written; no done; IDLE; a following command runs normally.
- RD_LAT = 3 build: len = 2 → 10 busy cycles; data is captured only on the last WAIT cycle.

Source files
------------

// File: rtl/mem1_copy_engine.sv
// Block-move engine for the single-port mem1: each word is one read, RD_LAT wait cycles, one write.
// Define CHECKSUM_EN to add an XOR checksum output over the copied words.
module mem1_copy_engine #(
    parameter int AW     = 5,
    parameter int DW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          mem_w_en,
    output logic          mem_mode,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam int WCW = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [DW-1:0]   data_q, data_d;

    logic            busy_q, done_q, wen_q, mode_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : RD;
                end
            end
            RD: begin
                wait_d  = WCW'(RD_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // Read data is only trusted on the final wait cycle.
                if (wait_q == '0) begin
                    data_d  = mem_data_out;
                    state_d = WR;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WR: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == {{AW{1'b0}}, 1'b1}) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            busy_q  <= (state_d == RD) || (state_d == WAIT) || (state_d == WR);
            done_q  <= (state_d == DONE);
            wen_q   <= (state_d == WR);
            mode_q  <= (state_d == RD);
            addr_q  <= (state_d == WR) ? dst_d : src_d;
            wdata_q <= data_d;
        end
    end

`ifdef CHECKSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == IDLE && start) begin
            csum_q <= '0;
        end else if (state_q == WR) begin
            csum_q <= csum_q ^ data_q;
        end
    end

    assign checksum = csum_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_w_en    = wen_q;
    assign mem_mode    = mode_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem1_copy_engine.sv
// Self-checking bench for mem1_copy_engine: memory model with RD_LAT read pipeline,
// per-cycle trace model of the port, and a reference copy of the memory contents.
module tb_mem1_copy_engine;
    parameter int RD_LAT = 1;
    localparam int WCYC = 2 + RD_LAT;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] src, dst;
    logic [5:0] len;
    logic       busy, done, mem_w_en, mem_mode;
    logic [4:0] mem_address, mem_data_in, mem_data_out;
`ifdef CHECKSUM_EN
    logic [4:0] checksum;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       we;
        logic       mode;
        logic       chk_a;
        logic [4:0] addr;
        logic [4:0] data;
    } exp_t;
    exp_t eq[$];

    logic [4:0] ref_mem [32];
    logic [4:0] mem     [32];
    logic [4:0] chk_model;
    logic       pl_en = 1'b0;
    logic [4:0] pl_addr, pl_data;
    logic [4:0] pipe_d [RD_LAT];
    logic       pipe_v [RD_LAT];
    logic [4:0] junk;
    int         acc_q[$];

    mem1_copy_engine #(.AW(5), .DW(5), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .mem_w_en     (mem_w_en),
        .mem_mode     (mem_mode),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
`ifdef CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // mem1 model: synchronous write, read data appears RD_LAT edges after issue, junk otherwise.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_w_en) mem[mem_address] <= mem_data_in;
        if (mem_w_en || mem_mode) acc_q.push_back(int'(mem_address));
        pipe_v[0] <= mem_mode;
        pipe_d[0] <= mem[mem_address];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        junk <= 5'($urandom);
    end

    assign mem_data_out = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : junk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit b, input bit d, input bit w, input bit m,
                                input bit ca, input int a, input logic [4:0] dt);
        exp_t e;
        e.busy = b; e.done = d; e.we = w; e.mode = m; e.chk_a = ca;
        e.addr = 5'(a); e.data = dt;
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            exp_t e;
            if (eq.size() > 0) e = eq.pop_front();
            else e = '0;
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("mem_w_en", mem_w_en, e.we);
            check("mem_mode", mem_mode, e.mode);
            if (e.chk_a) check("mem_address", mem_address, e.addr);
            if (e.we) check("mem_data_in", mem_data_in, e.data);
        end
    end

    task automatic poke(input int a, input logic [4:0] v);
        pl_en = 1'b1; pl_addr = 5'(a); pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Builds the expected per-cycle port trace from the copy rules, then drives the command.
    task automatic run_cmd(input int s, input int d, input int n, input int abort_k,
                           input int ign_at, output int busy_cnt, output int done_cyc);
        int k, m, sp, dp;
        bit ab;
        logic [4:0] v;
        ab = (abort_k >= 0) && (abort_k < n);
        k  = ab ? abort_k : n;
        chk_model = '0;
        eq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < k; i++) begin
            sp = (s + i) % 32;
            dp = (d + i) % 32;
            v  = ref_mem[sp];
            eq.push_back(mk(1, 0, 0, 1, 1, sp, 0));
            for (int w = 0; w < RD_LAT; w++) eq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
            eq.push_back(mk(1, 0, 1, 0, 1, dp, v));
            ref_mem[dp] = v;
            chk_model ^= v;
        end
        if (ab) eq.push_back(mk(1, 0, 0, 1, 1, (s + k) % 32, 0));
        else    eq.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        m = 1 + k * WCYC;
        src = 5'(s); dst = 5'(d); len = 6'(n); start = 1'b1;
        busy_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 34 * WCYC + 10; c++) begin
            @(posedge clk); #1;
            if (!ab && done_cyc != 0) break;
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) done_cyc = c;
            start = (c == ign_at);
            if (start) begin
                src = 5'($urandom); dst = 5'($urandom); len = 6'($urandom_range(1, 32));
            end
            if (ab && c == m) rst = 1'b1;
            else if (ab && c == m + 1) begin
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (!ab) check("done_cycle", done_cyc, n * WCYC + 1);
        @(posedge clk); #1;
        check("trace_consumed", eq.size(), 0);
        eq.delete();
        for (int a = 0; a < 32; a++) check($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
`ifdef CHECKSUM_EN
        check("checksum", checksum, ab ? 5'd0 : chk_model);
`endif
    endtask

    initial begin
        int bc, dc, n, ab, ign;
        rst = 1'b1; start = 1'b1; src = 5'd7; dst = 5'd9; len = 6'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w_en", mem_w_en, 0);
        check("rst_mode", mem_mode, 0);
        check("rst_address", mem_address, 0);
        check("rst_data_in", mem_data_in, 0);
`ifdef CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst = 1'b0; start = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 32; a++) poke(a, 5'($urandom));

        // Basic copy with literal expectations.
        poke(5, 5'd27); poke(6, 5'd26); poke(7, 5'd25);
        acc_q.delete();
        run_cmd(5, 20, 3, -1, 0, bc, dc);
        check("basic_busy_cycles", bc, 3 * WCYC);
        check("basic_mem20", mem[20], 27);
        check("basic_mem21", mem[21], 26);
        check("basic_mem22", mem[22], 25);
        check("basic_acc_count", acc_q.size(), 6);
        if (acc_q.size() == 6) begin
            check("basic_acc0", acc_q[0], 5);
            check("basic_acc1", acc_q[1], 20);
            check("basic_acc2", acc_q[2], 6);
            check("basic_acc3", acc_q[3], 21);
            check("basic_acc4", acc_q[4], 7);
            check("basic_acc5", acc_q[5], 22);
        end
`ifdef CHECKSUM_EN
        check("basic_checksum_lit", checksum, 24);
`endif

        // Wrap-around of the source pointer.
        poke(30, 5'd1); poke(31, 5'd2); poke(0, 5'd3); poke(1, 5'd4);
        acc_q.delete();
        run_cmd(30, 2, 4, -1, 0, bc, dc);
        check("wrap_mem2", mem[2], 1);
        check("wrap_mem3", mem[3], 2);
        check("wrap_mem4", mem[4], 3);
        check("wrap_mem5", mem[5], 4);
        check("wrap_acc_count", acc_q.size(), 8);
        if (acc_q.size() == 8) begin
            check("wrap_rd0", acc_q[0], 30);
            check("wrap_rd1", acc_q[2], 31);
            check("wrap_rd2", acc_q[4], 0);
            check("wrap_rd3", acc_q[6], 1);
        end

        // len = 0 with a start pulsed during DONE.
        acc_q.delete();
        run_cmd(4, 9, 0, -1, 1, bc, dc);
        check("len0_done_cycle", dc, 1);
        check("len0_no_access", acc_q.size(), 0);

        // Start pulsed mid-copy is ignored.
        run_cmd(3, 9, 5, -1, 4, bc, dc);

        // Reset after the second write of an 8-word copy.
        for (int a = 0; a < 8; a++) poke(a, 5'(a + 10));
        run_cmd(0, 16, 8, 2, 0, bc, dc);
        check("abort_mem16", mem[16], 10);
        check("abort_mem17", mem[17], 11);
        run_cmd(0, 16, 8, -1, 0, bc, dc);
        check("after_abort_mem23", mem[23], 17);

        // Full-memory copy with wrap.
        run_cmd(11, 12, 32, -1, 0, bc, dc);

        for (int t = 0; t < 25; t++) begin
            n   = $urandom_range(0, 32);
            ab  = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            ign = (ab < 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n * WCYC + 1) : 0;
            run_cmd($urandom_range(0, 31), $urandom_range(0, 31), n, ab, ign, bc, dc);
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
